// File: rtl/axi_lite_master.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_master
// Purpose  : Single-outstanding AXI-lite initiator turning one LSU/IFU request
//            into AR/R or AW/W/B traffic, with local misalignment rejection.
// Revision : 1.0 - initial release
// ============================================================================
module axi_lite_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_wen,
  input  logic [1:0]        i_req_size,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              o_resp_valid,
  output logic [DATA_W-1:0] o_resp_rdata,
  output logic [1:0]        o_resp_code,
  output logic              o_resp_misal,
  output logic              o_arvalid,
  input  logic              i_arready,
  output logic [ADDR_W-1:0] o_araddr,
  input  logic              i_rvalid,
  output logic              o_rready,
  input  logic [DATA_W-1:0] i_rdata,
  input  logic [1:0]        i_rresp,
  output logic              o_awvalid,
  input  logic              i_awready,
  output logic [ADDR_W-1:0] o_awaddr,
  output logic              o_wvalid,
  input  logic              i_wready,
  output logic [DATA_W-1:0] o_wdata,
  output logic [3:0]        o_wstrb,
  input  logic              i_bvalid,
  output logic              o_bready,
  input  logic [1:0]        i_bresp
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ERR  = 3'd1,
    S_RD_A = 3'd2,
    S_RD_D = 3'd3,
    S_WR   = 3'd4,
    S_WR_B = 3'd5,
    S_DONE = 3'd6
  } state_t;

  state_t            r_state, w_next;
  logic [1:0]        r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [3:0]        r_wstrb;
  logic              r_aw_done, r_w_done;
  logic [DATA_W-1:0] r_rdata;
  logic [1:0]        r_code;

  logic              w_accept;
  logic              w_misal;
  logic [1:0]        w_lane;
  logic [DATA_W-1:0] w_rshift;
  logic [DATA_W-1:0] w_load_data;
  logic [3:0]        w_strb;

  assign w_lane   = i_req_addr[1:0];
  assign w_accept = (r_state == S_IDLE) && i_req_valid;
  assign w_misal  = (i_req_size == 2'b11) ||
                    ((i_req_size == 2'b01) && w_lane[0]) ||
                    ((i_req_size == 2'b10) && (w_lane != 2'b00));
  assign w_rshift = i_rdata >> {r_addr[1:0], 3'b000};

  always_comb begin
    w_strb = 4'b1111;
    case (i_req_size)
      2'b00:   w_strb = 4'b0001 << w_lane;
      2'b01:   w_strb = 4'b0011 << w_lane;
      default: w_strb = 4'b1111;
    endcase
  end

  always_comb begin
    w_load_data = i_rdata;
    case (r_size)
      2'b00:   w_load_data = {{(DATA_W-8){1'b0}},  w_rshift[7:0]};
      2'b01:   w_load_data = {{(DATA_W-16){1'b0}}, w_rshift[15:0]};
      default: w_load_data = i_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    o_req_ready  = 1'b0;
    o_arvalid    = 1'b0;
    o_rready     = 1'b0;
    o_awvalid    = 1'b0;
    o_wvalid     = 1'b0;
    o_bready     = 1'b0;
    o_resp_valid = 1'b0;
    o_resp_misal = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) begin
          if (w_misal)        w_next = S_ERR;
          else if (i_req_wen) w_next = S_WR;
          else                w_next = S_RD_A;
        end
      end
      S_ERR: begin
        o_resp_valid = 1'b1;
        o_resp_misal = 1'b1;
        w_next       = S_IDLE;
      end
      S_RD_A: begin
        o_arvalid = 1'b1;
        if (i_arready) w_next = S_RD_D;
      end
      S_RD_D: begin
        o_rready = 1'b1;
        if (i_rvalid) w_next = S_DONE;
      end
      S_WR: begin
        o_awvalid = !r_aw_done;
        o_wvalid  = !r_w_done;
        // Each channel completes independently; leave once both have handshaken.
        if ((r_aw_done || i_awready) && (r_w_done || i_wready)) w_next = S_WR_B;
      end
      S_WR_B: begin
        o_bready = 1'b1;
        if (i_bvalid) w_next = S_DONE;
      end
      S_DONE: begin
        o_resp_valid = 1'b1;
        w_next       = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_size    <= 2'b00;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= 4'b0000;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_rdata   <= '0;
      r_code    <= 2'b00;
    end else begin
      if (w_accept) begin
        r_size    <= i_req_size;
        r_addr    <= i_req_addr;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
        r_rdata   <= '0;
        r_code    <= w_misal ? 2'b10 : 2'b00;
        if (i_req_wen && !w_misal) begin
          r_wdata <= i_req_wdata << {w_lane, 3'b000};
          r_wstrb <= w_strb;
        end
      end
      if (r_state == S_WR) begin
        if (i_awready) r_aw_done <= 1'b1;
        if (i_wready)  r_w_done  <= 1'b1;
      end
      if ((r_state == S_RD_D) && i_rvalid) begin
        r_code  <= i_rresp;
        r_rdata <= (i_rresp != 2'b00) ? '0 : w_load_data;
      end
      if ((r_state == S_WR_B) && i_bvalid) r_code <= i_bresp;
    end
  end

  assign o_araddr     = r_addr;
  assign o_awaddr     = r_addr;
  assign o_wdata      = r_wdata;
  assign o_wstrb      = r_wstrb;
  assign o_resp_rdata = r_rdata;
  assign o_resp_code  = r_code;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_lite_master
// Purpose  : Self-checking bench for axi_lite_master with a responsive slave
//            and a behavioural reference model of the request/response rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_lite_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req_valid, o_req_ready, i_req_wen;
  logic [1:0]  i_req_size;
  logic [31:0] i_req_addr, i_req_wdata;
  logic        o_resp_valid, o_resp_misal;
  logic [31:0] o_resp_rdata;
  logic [1:0]  o_resp_code;
  logic        o_arvalid, i_arready, i_rvalid, o_rready;
  logic [31:0] o_araddr, i_rdata;
  logic [1:0]  i_rresp;
  logic        o_awvalid, i_awready, o_wvalid, i_wready, i_bvalid, o_bready;
  logic [31:0] o_awaddr, o_wdata;
  logic [3:0]  o_wstrb;
  logic [1:0]  i_bresp;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  axi_lite_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_wen(i_req_wen),
    .i_req_size(i_req_size), .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
    .o_resp_valid(o_resp_valid), .o_resp_rdata(o_resp_rdata),
    .o_resp_code(o_resp_code), .o_resp_misal(o_resp_misal),
    .o_arvalid(o_arvalid), .i_arready(i_arready), .o_araddr(o_araddr),
    .i_rvalid(i_rvalid), .o_rready(o_rready), .i_rdata(i_rdata), .i_rresp(i_rresp),
    .o_awvalid(o_awvalid), .i_awready(i_awready), .o_awaddr(o_awaddr),
    .o_wvalid(o_wvalid), .i_wready(i_wready), .o_wdata(o_wdata), .o_wstrb(o_wstrb),
    .i_bvalid(i_bvalid), .o_bready(o_bready), .i_bresp(i_bresp)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Reference rules, written arithmetically from the interface description.
  function automatic bit ref_misal(input logic [1:0] size, input logic [31:0] addr);
    int a = int'(addr % 4);
    if (size == 2'd3) return 1'b1;
    if (size == 2'd1) return (a % 2) != 0;
    if (size == 2'd2) return a != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] size, input logic [31:0] addr,
                                           input logic [31:0] rd, input logic [1:0] resp);
    longint unsigned v = longint'(rd) / (longint'(1) << (8 * (addr % 4)));
    if (resp != 2'b00) return 32'd0;
    if (size == 2'd0) return 32'(v % 256);
    if (size == 2'd1) return 32'(v % 65536);
    return rd;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [31:0] wd, input logic [31:0] addr);
    longint unsigned v = longint'(wd) * (longint'(1) << (8 * (addr % 4)));
    return 32'(v % (longint'(1) << 32));
  endfunction

  function automatic logic [31:0] ref_wstrb(input logic [1:0] size, input logic [31:0] addr);
    int a = int'(addr % 4);
    if (size == 2'd0) return 32'(1 << a);
    if (size == 2'd1) return 32'(3 << a);
    return 32'hF;
  endfunction

  task automatic slave_idle();
    i_arready = 1'b0; i_rvalid = 1'b0; i_awready = 1'b0; i_wready = 1'b0; i_bvalid = 1'b0;
    i_rdata = $urandom; i_rresp = 2'b00; i_bresp = 2'b00;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valids"}, {25'd0, o_arvalid, o_rready, o_awvalid, o_wvalid, o_bready,
                              o_resp_valid, o_resp_misal}, 32'd0);
    check({tag, "_rdata"}, o_resp_rdata, 32'd0);
    check({tag, "_code"}, {30'd0, o_resp_code}, 32'd0);
    check({tag, "_araddr"}, o_araddr, 32'd0);
    check({tag, "_awaddr"}, o_awaddr, 32'd0);
    check({tag, "_wdata"}, o_wdata, 32'd0);
    check({tag, "_wstrb"}, {28'd0, o_wstrb}, 32'd0);
  endtask

  // One complete request; the slave side reacts at negedges with the given delays.
  task automatic run_txn(input string tag, input logic wen, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] rd, input logic [1:0] resp,
                         input int hd, input int wdly, input int dd);
    bit   misal = ref_misal(size, addr);
    int   ar_cnt = 0, aw_cnt = 0, w_cnt = 0, r_cnt = 0, b_cnt = 0;
    int   ar_hs = 0, aw_hs = 0, w_hs = 0;
    bit   done = 1'b0, wr_seen = 1'b0, any_valid = 1'b0;
    @(negedge clk);
    i_req_valid = 1'b1; i_req_wen = wen; i_req_size = size; i_req_addr = addr; i_req_wdata = wd;
    check({tag, "_req_ready"}, {31'd0, o_req_ready}, 32'd1);
    @(posedge clk);
    #1 i_req_valid = 1'b0; i_req_wdata = $urandom;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(negedge clk);
      if (o_arvalid || o_awvalid || o_wvalid) any_valid = 1'b1;
      if (o_arvalid) begin
        ar_cnt++;
        check({tag, "_araddr"}, o_araddr, addr);
        i_arready = (ar_cnt > hd);
        if (i_arready) ar_hs++;
      end else i_arready = 1'b0;
      if ((o_awvalid || o_wvalid) && !wr_seen) begin
        wr_seen = 1'b1;
        check({tag, "_aw_w_together"}, {31'd0, o_awvalid && o_wvalid}, 32'd1);
      end
      if (o_awvalid) begin
        aw_cnt++;
        check({tag, "_awaddr"}, o_awaddr, addr);
        i_awready = (aw_cnt > hd);
        if (i_awready) aw_hs++;
      end else i_awready = 1'b0;
      if (o_wvalid) begin
        w_cnt++;
        check({tag, "_wdata"}, o_wdata, ref_wdata(wd, addr));
        check({tag, "_wstrb"}, {28'd0, o_wstrb}, ref_wstrb(size, addr));
        i_wready = (w_cnt > wdly);
        if (i_wready) w_hs++;
      end else i_wready = 1'b0;
      if (o_rready) begin
        r_cnt++;
        i_rvalid = (r_cnt > dd);
        i_rdata  = i_rvalid ? rd : $urandom;
        i_rresp  = i_rvalid ? resp : 2'b00;
      end else i_rvalid = 1'b0;
      if (o_bready) begin
        b_cnt++;
        i_bvalid = (b_cnt > dd);
        i_bresp  = i_bvalid ? resp : 2'b00;
      end else i_bvalid = 1'b0;
      if (o_resp_valid) begin
        done = 1'b1;
        check({tag, "_resp_misal"}, {31'd0, o_resp_misal}, {31'd0, misal});
        check({tag, "_resp_code"}, {30'd0, o_resp_code}, misal ? 32'd2 : {30'd0, resp});
        check({tag, "_resp_rdata"}, o_resp_rdata,
              (misal || wen) ? 32'd0 : ref_load(size, addr, rd, resp));
      end
    end
    check({tag, "_completed"}, {31'd0, done}, 32'd1);
    slave_idle();
    check({tag, "_ar_hs"}, ar_hs, (!misal && !wen) ? 32'd1 : 32'd0);
    check({tag, "_aw_hs"}, aw_hs, (!misal && wen) ? 32'd1 : 32'd0);
    check({tag, "_w_hs"}, w_hs, (!misal && wen) ? 32'd1 : 32'd0);
    if (misal) check({tag, "_no_valid"}, {31'd0, any_valid}, 32'd0);
    @(negedge clk);
    check({tag, "_resp_one_cycle"}, {31'd0, o_resp_valid}, 32'd0);
    check({tag, "_back_to_back_ready"}, {31'd0, o_req_ready}, 32'd1);
  endtask

  task automatic reset_mid(input string tag, input logic wen);
    bit reached = 1'b0, spurious = 1'b0;
    @(negedge clk);
    i_req_valid = 1'b1; i_req_wen = wen; i_req_size = 2'b10; i_req_addr = 32'h8000_0010;
    i_req_wdata = 32'hCAFE_F00D;
    @(posedge clk);
    #1 i_req_valid = 1'b0;
    for (int cyc = 0; cyc < 10 && !reached; cyc++) begin
      @(negedge clk);
      if (wen) reached = o_awvalid && o_wvalid;
      else begin
        i_arready = o_arvalid;
        reached   = o_rready;
      end
    end
    check({tag, "_reached_phase"}, {31'd0, reached}, 32'd1);
    slave_idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_state(tag);
    check({tag, "_req_ready"}, {31'd0, o_req_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (o_resp_valid) spurious = 1'b1;
    end
    check({tag, "_no_resp"}, {31'd0, spurious}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    i_req_valid = 1'b0; i_req_wen = 1'b0; i_req_size = 2'b00; i_req_addr = '0; i_req_wdata = '0;
    slave_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;
    @(negedge clk);
    check("reset_req_ready", {31'd0, o_req_ready}, 32'd1);

    run_txn("ld_word",  1'b0, 2'b10, 32'h8000_0000, 32'h0, 32'hDEAD_BEEF, 2'b00, 0, 0, 0);
    run_txn("ld_byte3", 1'b0, 2'b00, 32'h8000_0003, 32'h0, 32'h1234_5678, 2'b00, 1, 0, 1);
    run_txn("ld_half2", 1'b0, 2'b01, 32'h8000_0002, 32'h0, 32'h1234_5678, 2'b00, 0, 0, 2);
    run_txn("st_byte1", 1'b1, 2'b00, 32'h8000_0001, 32'hAB,   32'h0, 2'b00, 1, 2, 0);
    run_txn("st_w_first", 1'b1, 2'b01, 32'h8000_0002, 32'h0000_BEEF, 32'h0, 2'b00, 3, 0, 1);
    run_txn("mis_st_half", 1'b1, 2'b01, 32'h8000_0001, 32'h1111, 32'h0, 2'b00, 0, 0, 0);
    run_txn("mis_ld_word", 1'b0, 2'b10, 32'h8000_0002, 32'h0, 32'h2222, 2'b00, 0, 0, 0);
    run_txn("mis_rsvd",    1'b0, 2'b11, 32'h8000_0000, 32'h0, 32'h3333, 2'b00, 0, 0, 0);
    run_txn("bresp_err", 1'b1, 2'b10, 32'h8000_0004, 32'h5555_AAAA, 32'h0, 2'b10, 0, 0, 0);
    run_txn("rresp_err", 1'b0, 2'b10, 32'h8000_0008, 32'h0, 32'h7777_8888, 2'b11, 0, 0, 0);

    // Stray responses while idle must not be accepted.
    @(negedge clk);
    i_rvalid = 1'b1; i_bvalid = 1'b1;
    @(negedge clk);
    check("stray_rready", {31'd0, o_rready}, 32'd0);
    check("stray_bready", {31'd0, o_bready}, 32'd0);
    slave_idle();

    for (int i = 0; i < 40; i++) begin
      logic [1:0]  rs = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      run_txn($sformatf("rand%0d", i), 1'($urandom), 2'($urandom),
              32'h8000_0000 | (32'($urandom) & 32'h0000_0FFF), $urandom, $urandom, rs,
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    reset_mid("rst_rd_d", 1'b0);
    reset_mid("rst_wr", 1'b1);
    run_txn("post_rst_ld", 1'b0, 2'b00, 32'h8000_0001, 32'h0, 32'hA1B2_C3D4, 2'b00, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
